// File: rtl/tile_drawer.sv
// tile_drawer: pixel engine that draws or erases one piano tile in a lane.
//
// A tile is a LANE_W x TILE_H filled rectangle whose leftmost and rightmost
// columns are painted BORDER_COLOUR. In erase mode the whole rectangle,
// border included, is painted BG_COLOUR. One pixel leaves per clock in
// raster order on the x/y/colour/plot interface the VGA adapter consumes.
// Rows at or below SCREEN_H are clipped (plot=0) but still take their cycle,
// so a request always lasts the same number of cycles.
//
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   start      one-cycle request, only looked at while idle
//   lane       target lane index
//   top_y      row of the tile's top edge
//   colour_in  tile fill colour
//   erase      1 = paint the rectangle background colour, no border
//   x, y       pixel coordinate
//   colour     pixel colour
//   plot       pixel write strobe
//   busy       high from the cycle after acceptance through the last pixel
//   done       one-cycle pulse at the end of every request
//   err        one-cycle pulse with done when the lane index was rejected
module tile_drawer #(
  parameter int X_ORIGIN = 120,
  parameter int LANE_W = 20,
  parameter int TILE_H = 40,
  parameter int NUM_LANES = 4,
  parameter int SCREEN_H = 240,
  parameter logic [2:0] BG_COLOUR = 3'b111,
  parameter logic [2:0] BORDER_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] lane,
  input  logic [7:0] top_y,
  input  logic [2:0] colour_in,
  input  logic       erase,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PXW = $clog2(LANE_W);
  localparam int PYW = $clog2(TILE_H);
  localparam logic [PXW-1:0] PX_LAST = PXW'(LANE_W - 1);
  localparam logic [PYW-1:0] PY_LAST = PYW'(TILE_H - 1);
  localparam logic [8:0] X0 = 9'(X_ORIGIN);
  localparam logic [8:0] LW9 = 9'(LANE_W);
  localparam logic [8:0] SH9 = 9'(SCREEN_H);
  localparam logic [2:0] NL3 = 3'(NUM_LANES);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [PXW-1:0] px, px_next;
  logic [PYW-1:0] py, py_next;
  logic [1:0] lane_q, lane_q_next;
  logic [7:0] top_q, top_q_next;
  logic [2:0] fill_q, fill_q_next;
  logic erase_q, erase_q_next;
  logic reject, reject_next;

  logic [8:0] x_next;
  logic [7:0] y_next;
  logic [2:0] colour_next;
  logic plot_next, busy_next, done_next, err_next;

  logic [8:0] pix_x;
  logic [8:0] y_full;
  logic lane_ok;

  // y_full is kept at 9 bits so a tile hanging off the bottom clips
  // instead of wrapping back onto the top rows.
  assign pix_x = X0 + 9'(lane_q) * LW9 + 9'(px);
  assign y_full = {1'b0, top_q} + 9'(py);
  assign lane_ok = ({1'b0, lane} < NL3);

  always_comb begin
    state_next = state;
    px_next = px;
    py_next = py;
    lane_q_next = lane_q;
    top_q_next = top_q;
    fill_q_next = fill_q;
    erase_q_next = erase_q;
    reject_next = reject;
    x_next = x;
    y_next = y;
    colour_next = colour;
    plot_next = 1'b0;
    busy_next = 1'b0;
    done_next = 1'b0;
    err_next = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (lane_ok) begin
            lane_q_next = lane;
            top_q_next = top_y;
            fill_q_next = colour_in;
            erase_q_next = erase;
            px_next = '0;
            py_next = '0;
            reject_next = 1'b0;
            busy_next = 1'b1;
            state_next = DRAW;
          end else begin
            reject_next = 1'b1;
            state_next = FINISH;
          end
        end
      end

      DRAW: begin
        x_next = pix_x;
        y_next = y_full[7:0];
        if (erase_q) begin
          colour_next = BG_COLOUR;
        end else if (px == '0 || px == PX_LAST) begin
          colour_next = BORDER_COLOUR;
        end else begin
          colour_next = fill_q;
        end
        plot_next = (y_full < SH9);
        busy_next = 1'b1;
        if (px == PX_LAST) begin
          px_next = '0;
          if (py == PY_LAST) begin
            state_next = FINISH;
          end else begin
            py_next = py + 1'b1;
          end
        end else begin
          px_next = px + 1'b1;
        end
      end

      FINISH: begin
        done_next = 1'b1;
        err_next = reject;
        reject_next = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      px <= '0;
      py <= '0;
      lane_q <= '0;
      top_q <= '0;
      fill_q <= '0;
      erase_q <= 1'b0;
      reject <= 1'b0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_next;
      px <= px_next;
      py <= py_next;
      lane_q <= lane_q_next;
      top_q <= top_q_next;
      fill_q <= fill_q_next;
      erase_q <= erase_q_next;
      reject <= reject_next;
      x <= x_next;
      y <= y_next;
      colour <= colour_next;
      plot <= plot_next;
      busy <= busy_next;
      done <= done_next;
      err <= err_next;
    end
  end

endmodule

// File: tb/tb_tile_drawer.sv
// Testbench for tile_drawer: directed and randomized tile requests checked
// against a pixel-by-pixel reference derived from the tile geometry.
// A second instance with three lanes exercises the lane-reject path.
module tb_tile_drawer;

  localparam int XO = 120;
  localparam int LW = 20;
  localparam int TH = 40;
  localparam int SH = 240;
  localparam int NPIX = LW * TH;

  logic clk = 1'b0;
  logic resetn, start, erase, start2;
  logic [1:0] lane, lane2;
  logic [7:0] top_y;
  logic [2:0] colour_in;

  logic [8:0] x, x2;
  logic [7:0] y, y2;
  logic [2:0] colour, colour2;
  logic plot, busy, done, err;
  logic plot2, busy2, done2, err2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tile_drawer u_dut (
    .clk(clk), .resetn(resetn), .start(start), .lane(lane), .top_y(top_y),
    .colour_in(colour_in), .erase(erase), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done), .err(err)
  );

  tile_drawer #(.NUM_LANES(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .start(start2), .lane(lane2), .top_y(top_y),
    .colour_in(colour_in), .erase(erase), .x(x2), .y(y2), .colour(colour2),
    .plot(plot2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of visible pixels for a tile whose top edge is at row top.
  function automatic int visible_pixels(input int top);
    int rows;
    rows = SH - top;
    if (rows < 0) rows = 0;
    if (rows > TH) rows = TH;
    return rows * LW;
  endfunction

  task automatic run_req(input int ln, input int top, input int col, input int er,
                         input bit poke_busy, input bit poke_finish, input bit scramble);
    int px, py, yfull, nplot, exp_col;
    bit vis;
    lane = 2'(ln);
    top_y = 8'(top);
    colour_in = 3'(col);
    erase = er[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", 32'(busy), 1);
    chk("accept_plot", 32'(plot), 0);
    chk("accept_done", 32'(done), 0);
    nplot = 0;
    for (int k = 1; k <= NPIX; k++) begin
      if (scramble) begin
        lane = 2'($urandom);
        top_y = 8'($urandom);
        colour_in = 3'($urandom);
        erase = 1'($urandom);
      end
      if (poke_busy && k == 50) begin
        start = 1'b1;
        lane = 2'((ln + 1) % 4);
      end
      if (poke_busy && k == 51) start = 1'b0;
      tick();
      px = (k - 1) % LW;
      py = (k - 1) / LW;
      yfull = top + py;
      vis = (yfull < SH);
      if (er != 0) exp_col = 7;
      else if (px == 0 || px == LW - 1) exp_col = 0;
      else exp_col = col;
      chk("x", 32'(x), XO + ln * LW + px);
      chk("y", 32'(y), yfull % 256);
      chk("colour", 32'(colour), exp_col);
      chk("plot", 32'(plot), 32'(vis));
      chk("busy", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      nplot += int'(plot);
    end
    start = 1'b0;
    if (poke_finish) begin
      start = 1'b1;
      lane = 2'((ln + 2) % 4);
    end
    tick();
    chk("done", 32'(done), 1);
    chk("err", 32'(err), 0);
    chk("fin_plot", 32'(plot), 0);
    chk("fin_busy", 32'(busy), 0);
    chk("hold_x", 32'(x), XO + ln * LW + LW - 1);
    chk("hold_y", 32'(y), (top + TH - 1) % 256);
    chk("nplot", 32'(nplot), visible_pixels(top));
    if (poke_finish) begin
      start = 1'b0;
      tick();
      chk("fin_ignored_busy", 32'(busy), 0);
      chk("fin_ignored_plot", 32'(plot), 0);
      chk("fin_ignored_done", 32'(done), 0);
    end
  endtask

  initial begin
    int nplot2;
    resetn = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    lane = '0;
    lane2 = '0;
    top_y = '0;
    colour_in = '0;
    erase = 1'b0;
    tick();
    tick();
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_colour", 32'(colour), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    resetn = 1'b1;
    tick();

    // reset in the middle of a draw
    lane = 2'd0;
    top_y = 8'd0;
    colour_in = 3'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 100; k++) tick();
    chk("mid_plot", 32'(plot), 1);
    chk("mid_x", 32'(x), XO + 19);
    resetn = 1'b0;
    tick();
    chk("mrst_plot", 32'(plot), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_x", 32'(x), 0);
    resetn = 1'b1;
    tick();
    chk("mrst_idle_busy", 32'(busy), 0);
    chk("mrst_idle_plot", 32'(plot), 0);

    run_req(1, 10, 4, 0, 1'b1, 1'b0, 1'b0);
    run_req(3, 0, 3, 1, 1'b0, 1'b0, 1'b1);
    run_req(0, 220, 2, 0, 1'b0, 1'b1, 1'b0);
    run_req(2, 250, 5, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              1'b0, 1'b0, 1'b1);
    end

    // reject on the three-lane instance
    lane2 = 2'd3;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("rej_plot0", 32'(plot2), 0);
    chk("rej_busy0", 32'(busy2), 0);
    chk("rej_done0", 32'(done2), 0);
    tick();
    chk("rej_done", 32'(done2), 1);
    chk("rej_err", 32'(err2), 1);
    chk("rej_plot", 32'(plot2), 0);
    chk("rej_busy", 32'(busy2), 0);
    tick();
    chk("rej_done_off", 32'(done2), 0);
    chk("rej_err_off", 32'(err2), 0);

    // a valid lane on the three-lane instance still draws
    lane2 = 2'd2;
    top_y = 8'd100;
    colour_in = 3'd1;
    erase = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    nplot2 = 0;
    for (int k = 1; k <= NPIX; k++) begin
      tick();
      nplot2 += int'(plot2);
    end
    chk("l3_nplot", 32'(nplot2), visible_pixels(100));
    chk("l3_last_x", 32'(x2), XO + 2 * LW + LW - 1);
    tick();
    chk("l3_done", 32'(done2), 1);
    chk("l3_err", 32'(err2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
